iter_divider: RTL and testbench
===============================

// Module: iter_divider
// PURPOSE
//  Radix-2 restoring divider that serves DIV/DIVU requests issued by the execute-stage multicycle controller.
//  The controller is the initiator; this block is the responder.
//  Accepts one request via valid/ready, iterates one quotient bit per cycle, then holds {hi,lo} with resp_valid until the requester takes it.
//  MIPS convention: lo = quotient, hi = remainder.
// PARAMETERS
//  WIDTH  32  operand/result width; iteration count = WIDTH
// PORTS
//  clk         in   1      clock
//  resetn      in   1      reset, synchronous, active-low
//  flush       in   1      sync abort (pipeline flushE); drops any in-flight op
//  req_valid   in   1      request present
//  req_ready   out  1      block can accept (state==IDLE)
//  req_signed  in   1      1=DIV (two's complement), 0=DIVU
//  a           in   WIDTH  dividend, sampled at accept
//  b           in   WIDTH  divisor, sampled at accept
//  resp_valid  out  1      result valid (state==DONE)
//  resp_ready  in   1      requester consumes result
//  hi          out  WIDTH  remainder, registered
//  lo          out  WIDTH  quotient, registered
// BEHAVIOUR
//  Reset (resetn=0 at posedge):
//  - state=IDLE; hi=lo=0; counter=0; resp_valid=0; req_ready=1 in the following cycle.
//  States: IDLE -> CALC -> FIXUP -> DONE -> IDLE.
//  IDLE, accept when req_valid&&req_ready&&!flush:
//  - Latch the magnitudes |a|,|b| (signed mode) or a,b (unsigned).
//  - Latch sign_q = a[W-1]^b[W-1] and sign_r = a[W-1] (both forced to 0 when unsigned).
//  - Clear the partial remainder; counter=0.
//  - b==0: fast path straight to DONE with lo={WIDTH{1'b1}}, hi=a (raw a, not magnitude); resp_valid in the cycle after the accept edge.
//  - Otherwise go to CALC.
//  CALC, one step per cycle:
//  - Shift {rem,quo} left 1; trial = rem - divisor.
//  - If trial >= 0: rem = trial, quo[0] = 1; else quo[0] = 0.
//  - Compare in WIDTH+1 bits so that unsigned 0xFFFFFFFF operands do not overflow.
//  - counter increments; after WIDTH steps (counter==WIDTH-1 at the edge) go to FIXUP.
//  FIXUP, 1 cycle:
//  - lo = sign_q ? -quo : quo; hi = sign_r ? -rem : rem; go to DONE.
//  - Remainder takes the sign of the dividend (truncating division).
//  - Signed 0x80000000 / -1 needs no special case: the magnitude path yields lo=0x80000000, hi=0 (wraps).
//  Latency, non-zero divisor, accept at edge E0:
//  - CALC spans edges E1..E32, FIXUP ends at E33.
//  - resp_valid is high from the cycle after E33, i.e. 34 cycles after the accept cycle.
//  DONE:
//  - resp_valid=1; hi/lo held stable while resp_ready=0.
//  - On resp_valid&&resp_ready, go to IDLE at that edge; req_ready=1 next cycle. No same-cycle re-accept.
//  - hi/lo keep the last result in IDLE until the next FIXUP or fast-path load.
//  flush:
//  - Priority over everything except reset; any state -> IDLE at the edge.
//  - Pending result is discarded: resp_valid=0 next cycle, hi/lo unchanged.
//  - A request presented in the flush cycle is NOT accepted.
//  - a and b are ignored except at accept; changing them mid-op has no effect.
//  - Reset mid-op behaves like flush, and additionally clears hi/lo.
// TESTING
//  1. DIVU a=100,b=7 -> lo=14,hi=2; resp_valid exactly 34 cycles after accept; req_ready=0 throughout.
//  2. DIV a=-7(0xFFFFFFF9),b=2 -> lo=0xFFFFFFFD,hi=0xFFFFFFFF; DIV a=7,b=-2 -> lo=0xFFFFFFFD,hi=1.
//  3. DIVU a=0xFFFFFFFF,b=1 -> lo=0xFFFFFFFF,hi=0; DIV a=0x80000000,b=0xFFFFFFFF -> lo=0x80000000,hi=0.
//  4. DIV a=5,b=0 -> resp_valid 1 cycle after accept, lo=0xFFFFFFFF,hi=5.
//  5. Accept, then flush 10 cycles later with req_valid=1 -> no resp_valid; req_ready=1 next cycle; next op 9/3 -> lo=3,hi=0.
//  6. Hold resp_ready=0 for 5 cycles in DONE -> resp_valid stays 1, hi/lo stable; return to IDLE on the handshake edge.

Source files
------------

// File: rtl/iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU. It retires one quotient bit per cycle and
// holds {hi,lo} (remainder, quotient) until the requester takes the result.
module iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP,
    DONE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             sign_q;
  logic             sign_r;

  logic             accept;
  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             take;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;

  // req_ready is a registered copy of (state == IDLE), so it can qualify the accept directly.
  assign accept = req_valid && req_ready && !flush;

  assign neg_a = req_signed && a[WIDTH-1];
  assign neg_b = req_signed && b[WIDTH-1];
  assign a_mag = neg_a ? -a : a;
  assign b_mag = neg_b ? -b : b;

  // The trial subtraction is one bit wider than the operands.
  // Shifting 0xFFFFFFFF into the partial remainder would otherwise lose the carry.
  assign rem_sh   = {rem, quo[WIDTH-1]};
  assign take     = (rem_sh >= {1'b0, divisor});
  assign rem_next = take ? WIDTH'(rem_sh - {1'b0, divisor}) : rem_sh[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], take};

  // NOTE: the iteration registers have no reset.
  // They are loaded on every accept, and their contents are never observed outside CALC/FIXUP.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem     <= '0;
      quo     <= a_mag;
      divisor <= b_mag;
      sign_q  <= neg_a ^ neg_b;
      sign_r  <= neg_a;
    end else if (state == CALC) begin
      rem <= rem_next;
      quo <= quo_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      counter    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else if (flush) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            counter   <= '0;
            req_ready <= 1'b0;
            if (b == '0) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              lo         <= '1;
              hi         <= a;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          counter <= counter + 1'b1;
          if (counter == LAST_STEP) state <= FIXUP;
        end
        FIXUP: begin
          lo         <= sign_q ? -quo : quo;
          hi         <= sign_r ? -rem : rem;
          state      <= DONE;
          resp_valid <= 1'b1;
        end
        DONE: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider.
// Expected results are queued when a request is accepted and popped when the response handshake completes.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } result_t;

  result_t     sb[$];
  int          vectors    = 0;
  int          miscompares = 0;
  logic [31:0] last_hi;
  logic [31:0] last_lo;

  always #5 clk = ~clk;

  iter_divider #(.WIDTH(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_signed (req_signed),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .hi         (hi),
    .lo         (lo)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for the response, and optionally stall the requester in DONE.
  task automatic do_op(input logic sgn, input logic [31:0] da, input logic [31:0] db,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                       input int exp_lat, input int hold);
    result_t r;
    int      n;
    bit      busy_ok;
    @(negedge clk);
    check("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid  = 1'b1;
    req_signed = sgn;
    a          = da;
    b          = db;
    sb.push_back('{hi: exp_hi, lo: exp_lo});
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    a          = $urandom;
    b          = $urandom;
    req_signed = ~sgn;
    n       = 0;
    busy_ok = 1'b1;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
      if (req_ready) busy_ok = 1'b0;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("no_ready_while_busy", 64'(busy_ok), 64'd1);
    r = sb.pop_front();
    check("lo", 64'(lo), 64'(r.lo));
    check("hi", 64'(hi), 64'(r.hi));
    resp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 64'(resp_valid), 64'd1);
      check("hold_hilo", {hi, lo}, {r.hi, r.lo});
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    @(negedge clk);
    check("post_hs_valid", 64'(resp_valid), 64'd0);
    check("post_hs_ready", 64'(req_ready), 64'd1);
    check("idle_keeps_hilo", {hi, lo}, {r.hi, r.lo});
    last_hi = r.hi;
    last_lo = r.lo;
  endtask

  initial begin
    resetn     = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_signed = 1'b0;
    a          = '0;
    b          = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    resetn = 1'b1;

    do_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 34, 0);
    do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 34, 0);
    do_op(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 34, 0);
    do_op(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 34, 0);
    do_op(1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 34, 0);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 34, 0);
    do_op(1'b0, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, 32'd2, 34, 0);
    do_op(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 34, 0);
    do_op(1'b1, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1, 0);
    do_op(1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1, 0);

    // An in-flight op is dropped by flush; the request shown in the flush cycle is ignored.
    @(negedge clk);
    req_valid  = 1'b1;
    req_signed = 1'b0;
    a          = 32'd1000;
    b          = 32'd3;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush     = 1'b1;
    req_valid = 1'b1;
    a         = 32'd50;
    b         = 32'd5;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    check("flush_ready", 64'(req_ready), 64'd1);
    check("flush_valid", 64'(resp_valid), 64'd0);
    check("flush_hilo", {hi, lo}, {last_hi, last_lo});
    begin
      bit quiet = 1'b1;
      repeat (40) begin
        @(negedge clk);
        if (resp_valid || !req_ready) quiet = 1'b0;
      end
      check("flush_no_resp", 64'(quiet), 64'd1);
    end
    do_op(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 34, 0);

    // Stall the requester in DONE.
    do_op(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 34, 5);

    // Reset mid-op aborts and clears hi/lo.
    @(negedge clk);
    req_valid  = 1'b1;
    req_signed = 1'b0;
    a          = 32'd77;
    b          = 32'd4;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    resetn = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check("midrst_hilo", {hi, lo}, 64'd0);
    check("midrst_valid", 64'(resp_valid), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd1);
    do_op(1'b0, 32'd77, 32'd4, 32'd19, 32'd1, 34, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
